// File: rtl/muldiv_unit_pkg.sv
// Shared control definitions: ALU control codes plus the multiply/divide
// unit's operation codes, FSM states and default operand width.
package muldiv_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Iterative ops occupy the low half of the encoding; bit 0 = signed, bit 1 = divide.
    function automatic logic md_is_iter(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[2] & op[0];
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_sign_adj.sv
// Combinational sign conditioning: passes the value through or returns its
// two's-complement negation. Used for absolute value in and signed result out.
module mdu_sign_adj #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one operand bit
// per cycle on unsigned magnitudes, signs restored in a final fix-up cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               zero_div;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   opb;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               take;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;

    assign signed_op = md_is_signed(op);

    mdu_sign_adj #(.W(WIDTH)) u_abs_a (
        .val(a), .neg(signed_op & a[WIDTH-1]), .res(a_mag)
    );
    mdu_sign_adj #(.W(WIDTH)) u_abs_b (
        .val(b), .neg(signed_op & b[WIDTH-1]), .res(b_mag)
    );

    // Multiply: {acc, quo} holds partial product above the remaining multiplier bits.
    assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);

    // Restoring divide: acc is the partial remainder, quo shifts dividend out and quotient in.
    assign rem_sh  = {acc, quo[WIDTH-1]};
    assign take    = rem_sh >= {1'b0, opb};
    assign rem_sub = rem_sh[WIDTH-1:0] - opb;

    mdu_sign_adj #(.W(2*WIDTH)) u_fix_prod (
        .val({acc, quo}), .neg(neg_lo), .res(prod_res)
    );
    mdu_sign_adj #(.W(WIDTH)) u_fix_quot (
        .val(quo), .neg(neg_lo), .res(quot_res)
    );
    mdu_sign_adj #(.W(WIDTH)) u_fix_rem (
        .val(acc), .neg(neg_hi), .res(rem_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            zero_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && md_is_iter(op)) begin
                        state    <= ST_CALC;
                        busy     <= 1'b1;
                        cnt      <= CW'(WIDTH);
                        is_div   <= md_is_div(op);
                        neg_lo   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= signed_op & a[WIDTH-1];
                        zero_div <= (b == '0);
                    end else if (start && op == OP_MTHI) begin
                        hi   <= a;
                        done <= 1'b1;
                    end else if (start && op == OP_MTLO) begin
                        lo   <= a;
                        done <= 1'b1;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        lo   <= zero_div ? '1 : quot_res;
                        hi   <= rem_res;
                        div0 <= zero_div;
                    end else begin
                        {hi, lo} <= prod_res;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Working registers need no reset: every operation reloads them at accept.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start && md_is_iter(op)) begin
            acc <= '0;
            quo <= a_mag;
            opb <= b_mag;
        end else if (state == ST_CALC) begin
            if (is_div) begin
                acc <= take ? rem_sub : rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], take};
            end else begin
                acc <= mul_sum[WIDTH:1];
                quo <= {mul_sum[0], quo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 8..64.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request strobe, sampled at the rising edge of clk.
REQ-005 op  input  3  operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 a  input  WIDTH  operand A (multiplicand/dividend/move source).
REQ-007 b  input  WIDTH  operand B (multiplier/divisor).
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-010 div0  output  1  sticky flag: last completed divide had b==0.
REQ-011 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-013 The unit SHALL accept a request when start==1 and busy==0; start while busy==1 SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, CALC, FIX; IDLE->CALC on accepted MULT/MULTU/DIV/DIVU; CALC->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-015 Accept at edge T: busy SHALL be 1 from T+1 through T+WIDTH+1, and 0 with done==1 at T+WIDTH+2 when hi/lo update.
REQ-016 CALC SHALL process one operand bit per cycle (shift-add multiply, restoring divide) on unsigned magnitudes, using a down-counter of $clog2(WIDTH+1) bits.
REQ-017 MULT/DIV SHALL latch operand signs at accept, use absolute values, and negate results in FIX as required.
REQ-018 Multiply SHALL yield the full 2*WIDTH-bit product: upper half in hi, lower half in lo.
REQ-019 Divide SHALL yield a quotient truncated toward zero in lo and a remainder in hi; the remainder sign follows the dividend.
REQ-020 DIV with a=MIN_INT, b=-1 SHALL give lo=MIN_INT, hi=0, with no flag.
REQ-021 Divide with b==0 SHALL complete with normal latency, lo=all ones, hi=a, and div0=1; any other completed divide SHALL clear div0; multiplies leave div0 unchanged.
REQ-022 MTHI/MTLO accepted at T SHALL write a to hi/lo at T+1 with done=1 at T+1, and busy SHALL stay 0.
REQ-023 Reserved op codes SHALL be ignored: no state change and no done.
REQ-024 hi/lo SHALL hold their previous values throughout CALC and change only at the done edge.
REQ-025 Operands SHALL be captured at accept; a/b/op changes during busy SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accept after rst_n deasserts SHALL behave as from cold reset.

Structure
REQ-028 Op encodings, FSM state encodings and WIDTH default SHALL reside in the shared definitions package/header alongside the existing ALU control codes.
REQ-029 Sign conditioning (absolute value in, conditional negate out) SHALL be a combinational sub-module mdu_sign_adj, instantiated for operand and result paths.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU a=100 b=0 -> done at T+34, lo=0xFFFFFFFF, hi=100, div0=1; next DIVU 9/4 -> lo=2, hi=1, div0=0.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-034 Start MULTU, pulse start with MTLO at T+5, assert rst_n=0 at T+10 -> second request ignored, no done, all outputs 0 during reset.
REQ-035 WIDTH=8: MTHI a=0x5A -> hi=0x5A and done at T+1, busy never 1; DIVU 200/7 -> done at T+10, lo=28, hi=4.
